// File: rtl/ofm_write_buffer_2_pkg.sv
// Shared sizes, drain FSM encoding and lane-mask helper for the OFM write buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ofm_write_buffer_2_pkg;

    localparam int SYSTOLIC_SIZE = 16;
    localparam int DATA_WIDTH    = 16;
    localparam int LANE_W        = SYSTOLIC_SIZE * DATA_WIDTH;
    localparam int TILE_W        = SYSTOLIC_SIZE * LANE_W;
    localparam int CH_W          = $clog2(SYSTOLIC_SIZE);

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN      = 2'd1,
        GAP        = 2'd2
    } drain_state_t;

    // Bit p set when lane p lies below the valid pixel count.
    function automatic logic [SYSTOLIC_SIZE-1:0] lane_mask(input logic [4:0] size);
        logic [SYSTOLIC_SIZE-1:0] m;
        for (int p = 0; p < SYSTOLIC_SIZE; p++) begin
            m[p] = (p < int'(size));
        end
        return m;
    endfunction

endpackage

// File: rtl/ofm_tile_bank.sv
// One tile bank: captures a full tile plus its sizes, holds a full flag, reads one channel.
// Latency: capture visible the cycle after the capture edge; read mux is combinational.
// Backpressure: owner only captures into an empty bank and frees it after the drain.
module ofm_tile_bank
    import ofm_write_buffer_2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              capture,
    input  logic              free,
    input  logic [TILE_W-1:0] tile_in,
    input  logic [4:0]        wgt_in,
    input  logic [4:0]        ofm_in,
    input  logic [CH_W-1:0]   rd_ch,
    output logic              full,
    output logic [4:0]        wgt_size,
    output logic [4:0]        ofm_size,
    output logic [LANE_W-1:0] rd_data
);

    logic [LANE_W-1:0] chan_q [SYSTOLIC_SIZE];

    // Full flag: set on capture, dropped when the drain frees the bank or on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (capture) begin
            full <= 1'b1;
        end else if (free) begin
            full <= 1'b0;
        end
    end

    // Tile payload and its sizes, stored channel-major so a channel is one row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wgt_size <= '0;
            ofm_size <= '0;
            for (int f = 0; f < SYSTOLIC_SIZE; f++) begin
                chan_q[f] <= '0;
            end
        end else if (capture) begin
            wgt_size <= wgt_in;
            ofm_size <= ofm_in;
            for (int f = 0; f < SYSTOLIC_SIZE; f++) begin
                chan_q[f] <= tile_in[f*LANE_W +: LANE_W];
            end
        end
    end

    assign rd_data = chan_q[rd_ch];

endmodule

// File: rtl/ofm_write_buffer_2.sv
// Ping-pong tile buffer: captures systolic tiles, drains one output channel per cycle.
// Latency: load at edge k -> write/wr_en high in cycle k+2 with channel 0; channel c at k+2+c.
// Backpressure: load_ready low when both banks are full; a load then is dropped and sets overflow.
module ofm_write_buffer_2
    import ofm_write_buffer_2_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     load,
    input  logic [TILE_W-1:0]        data_in,
    input  logic [4:0]               read_wgt_size,
    input  logic [4:0]               write_ofm_size,
    output logic                     load_ready,
    output logic                     write,
    output logic                     wr_en,
    output logic [LANE_W-1:0]        wr_data,
    output logic [SYSTOLIC_SIZE-1:0] wr_mask,
    output logic                     busy,
    output logic                     overflow
);

    drain_state_t      state, state_nxt;
    logic [CH_W-1:0]   ch, ch_nxt;
    logic              wr_bank, rd_bank;
    logic [1:0]        full, cap, free;
    logic [4:0]        wgt_q [2];
    logic [4:0]        ofm_q [2];
    logic [LANE_W-1:0] bank_rd [2];
    logic              last_ch;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ofm_tile_bank u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (start),
            .capture  (cap[b]),
            .free     (free[b]),
            .tile_in  (data_in),
            .wgt_in   (read_wgt_size),
            .ofm_in   (write_ofm_size),
            .rd_ch    (ch),
            .full     (full[b]),
            .wgt_size (wgt_q[b]),
            .ofm_size (ofm_q[b]),
            .rd_data  (bank_rd[b])
        );
    end

    // Bank strobes: capture into the fill bank if empty, free the drain bank in GAP.
    always_comb begin
        cap  = '0;
        free = '0;
        if (!start && load && !full[wr_bank]) begin
            cap[wr_bank] = 1'b1;
        end
        if (!start && state == GAP) begin
            free[rd_bank] = 1'b1;
        end
    end

    // Fill and drain pointers alternate banks after each capture / each drained tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else if (start) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (|cap) begin
                wr_bank <= ~wr_bank;
            end
            if (state == GAP) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Last channel: reached the latched channel count (a count of 0 or 1 still gives one
    // cycle), or the top channel, so an out-of-range count can never stall the drain.
    assign last_ch = (({2'b00, ch} + 6'd1) >= {1'b0, wgt_q[rd_bank]}) || (&ch);

    // Drain FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DRAIN_IDLE;
            ch    <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
        end
    end

    // Drain FSM next state: IDLE waits for a full bank, DRAIN walks channels, GAP frees.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        case (state)
            DRAIN_IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = DRAIN;
                    ch_nxt    = '0;
                end
            end
            DRAIN: begin
                if (last_ch) begin
                    state_nxt = GAP;
                end else begin
                    ch_nxt = ch + 1'b1;
                end
            end
            GAP:     state_nxt = DRAIN_IDLE;
            default: state_nxt = DRAIN_IDLE;
        endcase
        if (start) begin
            state_nxt = DRAIN_IDLE;
            ch_nxt    = '0;
        end
    end

    // Registered outputs, one cycle behind the FSM so data and write pulse line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write      <= 1'b0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_mask    <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else if (start) begin
            write      <= 1'b0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_mask    <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_en      <= (state == DRAIN);
            write      <= (state == DRAIN) && (ch == '0);
            wr_data    <= (state == DRAIN) ? bank_rd[rd_bank] : '0;
            wr_mask    <= (state == DRAIN) ? lane_mask(ofm_q[rd_bank]) : '0;
            load_ready <= !(full[0] && full[1]);
            busy       <= (|full) || (state != DRAIN_IDLE);
            if (load && full[wr_bank]) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ofm_write_buffer_2.md
# ofm_write_buffer_2

Ping-pong output buffer between the systolic array and the OFM write path. It captures one finished tile of results (SYSTOLIC_SIZE pixels × SYSTOLIC_SIZE filters) from the array, then drains it one output channel per cycle as lane-parallel write data. It generates the `write` pulse that starts the OFM write address controller. Its drain cadence matches that controller's channel sequence exactly, so data and address arrive in the same cycle.

## Interface
- SYSTOLIC_SIZE, 16, array dimension; lanes per write and maximum channels per tile
- DATA_WIDTH, 16, bits per OFM element
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- start  in  1  layer start; synchronous flush of both banks and the drain FSM
- load  in  1  tile valid from the array; one-cycle pulse
- data_in  in  SYSTOLIC_SIZE*SYSTOLIC_SIZE*DATA_WIDTH  tile; element (filter f, pixel p) at bits [(f*SYSTOLIC_SIZE+p)*DATA_WIDTH +: DATA_WIDTH]
- read_wgt_size  in  5  channels in the tile, legal range 2..SYSTOLIC_SIZE
- write_ofm_size  in  5  valid pixel lanes for the current tile, range 1..SYSTOLIC_SIZE
- load_ready  out  1  at least one bank is free
- write  out  1  one-cycle pulse on the first drain cycle of each tile
- wr_en  out  1  OFM RAM write enable
- wr_data  out  SYSTOLIC_SIZE*DATA_WIDTH  lane p = element (current channel, p)
- wr_mask  out  SYSTOLIC_SIZE  bit p set iff p < latched write_ofm_size
- busy  out  1  either bank full or drain active
- overflow  out  1  sticky; a load arrived with load_ready=0; cleared by start or reset

## Operation
- Two banks (0 and 1), each holding one tile plus its latched read_wgt_size and write_ofm_size, and a full flag.
- Fill pointer (wr_bank) and drain pointer (rd_bank) each toggle after use.
- Load: if load=1 and bank[wr_bank] is not full, capture data_in and the size inputs, set full, and toggle wr_bank.
- If load=1 while both banks are full, drop the tile, leave the banks unchanged, and set overflow.
- Drain FSM states:
  - IDLE: if bank[rd_bank] is full, go to DRAIN with ch=0.
  - DRAIN: per cycle, wr_en=1 and wr_data = channel ch of bank[rd_bank]; write=1 only when ch=0. When ch == latched read_wgt_size-1, go to GAP; otherwise increment ch.
  - GAP: one cycle with wr_en=0. Clear full[rd_bank], toggle rd_bank, go to IDLE.
- Per-tile timeline: N = read_wgt_size, so a tile occupies N DRAIN cycles plus 1 GAP cycle.
- After GAP there is always one IDLE cycle, so consecutive write pulses are at least N+2 cycles apart. This meets the address controller's minimum spacing of N+1.
- Masking: wr_mask is derived from the latched write_ofm_size, not the live input. Masked lanes still carry buffer data; the RAM ignores them.
- read_wgt_size=1 is a configuration error. The block still emits exactly one DRAIN cycle.
- start:
  - clears both full flags, wr_bank, rd_bank, ch and overflow;
  - forces the FSM to IDLE and drives wr_en=0 and write=0 in the following cycle;
  - takes priority over a simultaneous load (that load is dropped without setting overflow).
- Load and GAP in the same cycle: when both banks are full, load_ready is still 0 during GAP, so the load counts as overflow. The freed bank becomes visible on the next cycle.

## Timing
- All outputs are registered.
- Reset values: write=0, wr_en=0, wr_data=0, wr_mask=0, load_ready=1, busy=0, overflow=0; FSM in IDLE.
- Latency:
  - load accepted at edge k: full is set at k;
  - FSM enters DRAIN at edge k+1;
  - write and wr_en are high in cycle k+2, carrying channel 0.
- Channel c appears in cycle k+2+c.
- load_ready = !(full[0] && full[1]), registered. It drops the cycle after the second bank fills and rises the cycle after GAP.
- Reset mid-drain: outputs go to reset values immediately (asynchronously). No partial-tile resume.

## Structure
- Shared package: SYSTOLIC_SIZE, DATA_WIDTH, and the DRAIN_IDLE/DRAIN/GAP state encodings (2 bits).
- Sub-module ofm_tile_bank: a single bank with capture, full flag and channel-select read mux. Instantiate it twice.

## Test plan
- Single tile: N=4, size=16, element value = f*16+p, load at cycle 0 → write in cycle 2; wr_en in cycles 2–5; cycle 3 lane 5 = 21; wr_mask=0xFFFF.
- Partial lanes: size=13 → wr_mask=0x1FFF on every DRAIN cycle; lanes 13–15 ignored by checker.
- Back-to-back: loads at cycles 0 and 1 with N=16 → write pulses at cycles 2 and 20; load_ready=0 from cycle 2 until cycle 19.
- Overflow: three loads at cycles 0, 1, 2 with N=16 → third tile dropped; overflow=1; only two tiles emitted.
- start mid-drain: start at DRAIN ch=3 → wr_en=0 next cycle; load_ready=1; overflow=0; a subsequent load drains from ch=0.
- Async reset during DRAIN → all outputs at reset values before the next clock edge.
